// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state, port identifiers and wait-state counter width
package mem_responder_pkg;
    localparam int WS_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_e;
    typedef enum logic {PORT_INSTR, PORT_DATA} port_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: combinational two-way round-robin grant
//   instr_req_i / data_req_i : pending access bits
//   last_grant_i             : port granted most recently
//   grant_valid_o / grant_o  : some request pending / port to serve
module mem_arbiter
    import mem_responder_pkg::*;
(
    input  logic  instr_req_i,
    input  logic  data_req_i,
    input  port_e last_grant_i,
    output logic  grant_valid_o,
    output port_e grant_o
);
    always_comb begin
        grant_valid_o = instr_req_i | data_req_i;
        grant_o = PORT_INSTR;
        if (instr_req_i && data_req_i) begin
            // on a tie the port that lost last time wins
            if (last_grant_i == PORT_INSTR) grant_o = PORT_DATA;
        end else if (data_req_i) begin
            grant_o = PORT_DATA;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates an instruction and a data master onto one 16-bit SRAM
//   clk, reset (sync, active-low)
//   instr_m_*  : read-only instruction master (addr, access in; ack, data_out out)
//   data_m_*   : read/write data master with byte enables
//   sram_*     : SRAM strobes, address, write data, byte enables; sram_rdata in
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_out,
    input  logic [18:0] data_m_addr,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [1:0]  sram_be
);
    state_e            state_q;
    port_e             port_q;
    port_e             last_grant_q;
    logic [WS_W-1:0]   cnt_q;
    logic [18:0]       addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q;
    logic              we_q;
    logic [1:0]        be_q;
    logic              grant_valid;
    port_e             grant;
    logic              in_access;
    logic              in_ack;

    mem_arbiter u_arb (
        .instr_req_i  (instr_m_access),
        .data_req_i   (data_m_access),
        .last_grant_i (last_grant_q),
        .grant_valid_o(grant_valid),
        .grant_o      (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT_INSTR;
            last_grant_q <= PORT_INSTR;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (grant_valid) begin
                    state_q      <= ST_ACCESS;
                    cnt_q        <= WS_W'(WAIT_STATES);
                    port_q       <= grant;
                    last_grant_q <= grant;
                    if (grant == PORT_DATA) begin
                        addr_q  <= data_m_addr;
                        wdata_q <= data_m_data_in;
                        we_q    <= data_m_wr_en;
                        be_q    <= data_m_bytesel;
                    end else begin
                        addr_q  <= instr_m_addr;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                        be_q    <= 2'b11;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                        // writes return zero so the master never sees stale bus data
                        rdata_q <= we_q ? 16'h0000 : sram_rdata;
                    end else begin
                        cnt_q <= cnt_q - WS_W'(1);
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // outputs decode directly from registered state, so they are glitch-free and zero when idle
    assign in_access        = (state_q == ST_ACCESS);
    assign in_ack           = (state_q == ST_ACK);
    assign sram_ce          = in_access;
    assign sram_we          = in_access & we_q;
    assign sram_be          = in_access ? be_q : 2'b00;
    assign sram_addr        = in_access ? addr_q : '0;
    assign sram_wdata       = in_access ? wdata_q : '0;
    assign instr_m_ack      = in_ack && (port_q == PORT_INSTR);
    assign data_m_ack       = in_ack && (port_q == PORT_DATA);
    assign instr_m_data_out = instr_m_ack ? rdata_q : '0;
    assign data_m_data_out  = data_m_ack ? rdata_q : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder (WAIT_STATES 1 and 0)
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [18:0] i_addr, d_addr, s_addr;
    logic        i_acc, i_ack, d_acc, d_ack, d_wr, s_ce, s_we;
    logic [15:0] i_dout, d_din, d_dout, s_wdata, s_rdata;
    logic [1:0]  d_be, s_be;

    logic [18:0] z_i_addr, z_s_addr;
    logic        z_i_acc, z_i_ack, z_d_ack, z_s_ce, z_s_we;
    logic [15:0] z_i_dout, z_d_dout, z_s_wdata, z_s_rdata;
    logic [1:0]  z_s_be;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [256];
    logic [15:0] ref_mem  [256];
    bit          init_done = 1'b0;

    mem_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .instr_m_addr(i_addr), .instr_m_access(i_acc), .instr_m_ack(i_ack), .instr_m_data_out(i_dout),
        .data_m_addr(d_addr), .data_m_data_in(d_din), .data_m_data_out(d_dout), .data_m_access(d_acc),
        .data_m_ack(d_ack), .data_m_wr_en(d_wr), .data_m_bytesel(d_be),
        .sram_addr(s_addr), .sram_wdata(s_wdata), .sram_rdata(s_rdata),
        .sram_ce(s_ce), .sram_we(s_we), .sram_be(s_be)
    );

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .instr_m_addr(z_i_addr), .instr_m_access(z_i_acc), .instr_m_ack(z_i_ack), .instr_m_data_out(z_i_dout),
        .data_m_addr(19'h0), .data_m_data_in(16'h0), .data_m_data_out(z_d_dout), .data_m_access(1'b0),
        .data_m_ack(z_d_ack), .data_m_wr_en(1'b0), .data_m_bytesel(2'b00),
        .sram_addr(z_s_addr), .sram_wdata(z_s_wdata), .sram_rdata(z_s_rdata),
        .sram_ce(z_s_ce), .sram_we(z_s_we), .sram_be(z_s_be)
    );

    function automatic logic [15:0] init_word(int i);
        return (i == 8'h45) ? 16'hBEEF : 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    // SRAM model: asynchronous read, byte-masked synchronous write
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (s_ce && s_we) begin
            if (s_be[0]) sram_mem[s_addr[7:0]][7:0]  <= s_wdata[7:0];
            if (s_be[1]) sram_mem[s_addr[7:0]][15:8] <= s_wdata[15:8];
        end
    end
    assign s_rdata   = s_ce   ? sram_mem[s_addr[7:0]]   : 16'hDEAD;
    assign z_s_rdata = z_s_ce ? sram_mem[z_s_addr[7:0]] : 16'hDEAD;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int          r_lat, r_ce, r_we;
    logic [15:0] r_dout;
    bit          r_strobe_ok, r_post_ok;

    task automatic run_txn(input bit is_data, input bit wr, input logic [18:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
        logic [1:0] xbe;
        xbe = is_data ? be : 2'b11;
        r_lat = -1; r_ce = 0; r_we = 0; r_dout = '0; r_strobe_ok = 1'b1; r_post_ok = 1'b1;
        if (is_data) begin
            d_addr = addr; d_din = wd; d_wr = wr; d_be = be; d_acc = 1'b1;
        end else begin
            i_addr = addr; i_acc = 1'b1;
        end
        for (int n = 1; n <= 20 && r_lat < 0; n++) begin
            tick;
            if (s_ce) begin
                r_ce++;
                if (s_we) r_we++;
                if (s_addr !== addr || s_be !== xbe || s_we !== (is_data && wr) || (is_data && wr && s_wdata !== wd))
                    r_strobe_ok = 1'b0;
            end
            if (n == 1) begin
                d_addr = 19'($urandom); d_din = 16'($urandom); d_wr = 1'($urandom);
                d_be = 2'($urandom); i_addr = 19'($urandom);
            end
            if ((is_data ? i_ack : d_ack) !== 1'b0) r_strobe_ok = 1'b0;
            if ((is_data ? d_ack : i_ack) === 1'b1) begin
                r_lat = n;
                r_dout = is_data ? d_dout : i_dout;
                d_acc = 1'b0;
                i_acc = 1'b0;
            end else if (i_dout !== 16'h0 || d_dout !== 16'h0) begin
                r_post_ok = 1'b0;
            end
        end
        tick;
        if (i_ack !== 1'b0 || d_ack !== 1'b0 || i_dout !== 16'h0 || d_dout !== 16'h0) r_post_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; i_acc = 1'b1; d_acc = 1'b1; d_wr = 1'b1; d_be = 2'b11;
        i_addr = 19'($urandom); d_addr = 19'($urandom); d_din = 16'($urandom);
        repeat (3) tick;
        checks++;
        if ({i_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b expected 00", {i_ack, d_ack}); end
        checks++;
        if ({i_dout, d_dout} !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h expected 0", {i_dout, d_dout}); end
        checks++;
        if ({s_ce, s_we, s_be} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b expected 0000", {s_ce, s_we, s_be}); end
        checks++;
        if ({s_addr, s_wdata} !== 35'h0) begin errors++; $display("FAIL reset_addr_wdata got %h expected 0", {s_addr, s_wdata}); end
        i_acc = 1'b0; d_acc = 1'b0; d_wr = 1'b0;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_read;
        run_txn(1'b1, 1'b0, 19'h12345, 16'h0, 2'b11);
        checks++;
        if (r_lat !== 3) begin errors++; $display("FAIL read_latency got %0d expected 3", r_lat); end
        checks++;
        if (r_dout !== 16'hBEEF) begin errors++; $display("FAIL read_data got %h expected beef", r_dout); end
        checks++;
        if (r_ce !== 2 || r_we !== 0 || !r_strobe_ok) begin
            errors++; $display("FAIL read_strobes got ce=%0d we=%0d ok=%0d expected ce=2 we=0 ok=1", r_ce, r_we, r_strobe_ok);
        end
        checks++;
        if (!r_post_ok) begin errors++; $display("FAIL read_single_pulse got extra ack/data expected none"); end
    endtask

    task automatic test_write;
        run_txn(1'b1, 1'b1, 19'h00010, 16'hA55A, 2'b10);
        ref_mem[8'h10][15:8] = 8'hA5;
        checks++;
        if (r_lat !== 3) begin errors++; $display("FAIL write_latency got %0d expected 3", r_lat); end
        checks++;
        if (r_dout !== 16'h0) begin errors++; $display("FAIL write_data_out got %h expected 0000", r_dout); end
        checks++;
        if (r_ce !== 2 || r_we !== 2 || !r_strobe_ok) begin
            errors++; $display("FAIL write_strobes got ce=%0d we=%0d ok=%0d expected ce=2 we=2 ok=1", r_ce, r_we, r_strobe_ok);
        end
        run_txn(1'b0, 1'b0, 19'h40010, 16'h0, 2'b00);
        checks++;
        if (r_lat !== 3 || r_dout !== ref_mem[8'h10]) begin
            errors++; $display("FAIL write_readback got lat=%0d %h expected lat=3 %h", r_lat, r_dout, ref_mem[8'h10]);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            bit          is_data, wr;
            logic [18:0] a;
            logic [15:0] wd, exp;
            logic [1:0]  be;
            is_data = 1'($urandom); wr = is_data & 1'($urandom);
            a = 19'($urandom); wd = 16'($urandom); be = 2'($urandom);
            exp = wr ? 16'h0 : ref_mem[a[7:0]];
            run_txn(is_data, wr, a, wd, be);
            if (wr && be[0]) ref_mem[a[7:0]][7:0] = wd[7:0];
            if (wr && be[1]) ref_mem[a[7:0]][15:8] = wd[15:8];
            checks++;
            if (r_lat !== 3 || r_dout !== exp) begin
                errors++; $display("FAIL random_%0d got lat=%0d %h expected lat=3 %h", k, r_lat, r_dout, exp);
            end
            checks++;
            if (!r_strobe_ok || !r_post_ok || r_ce !== 2) begin
                errors++; $display("FAIL random_strobes_%0d got ok=%0d post=%0d ce=%0d expected 1 1 2", k, r_strobe_ok, r_post_ok, r_ce);
            end
        end
    endtask

    task automatic test_contention;
        int dn, in_n;
        logic [15:0] dv, iv;
        dn = -1; in_n = -1; dv = '0; iv = '0;
        reset = 1'b0; tick; tick; reset = 1'b1;
        d_addr = 19'h00033; d_wr = 1'b0; d_be = 2'b11; i_addr = 19'h00077;
        d_acc = 1'b1; i_acc = 1'b1;
        for (int n = 1; n <= 30 && (dn < 0 || in_n < 0); n++) begin
            tick;
            if (d_ack === 1'b1) begin dn = n; dv = d_dout; d_acc = 1'b0; end
            if (i_ack === 1'b1) begin in_n = n; iv = i_dout; i_acc = 1'b0; end
        end
        d_acc = 1'b0; i_acc = 1'b0;
        tick;
        checks++;
        if (dn !== 3) begin errors++; $display("FAIL contention_data_first got %0d expected 3", dn); end
        checks++;
        if (in_n !== dn + 4) begin errors++; $display("FAIL contention_instr_gap got %0d expected %0d", in_n, dn + 4); end
        checks++;
        if (dv !== ref_mem[8'h33] || iv !== ref_mem[8'h77]) begin
            errors++; $display("FAIL contention_data got %h %h expected %h %h", dv, iv, ref_mem[8'h33], ref_mem[8'h77]);
        end
    endtask

    task automatic test_back_to_back;
        bit   seq [8];
        int   t [8];
        int   cnt;
        bit   ok, data_ok;
        cnt = 0; ok = 1'b1; data_ok = 1'b1;
        d_addr = 19'h00100; d_wr = 1'b0; d_be = 2'b01; i_addr = 19'h7FF21;
        d_acc = 1'b1; i_acc = 1'b1;
        for (int n = 1; n <= 60 && cnt < 8; n++) begin
            tick;
            if (d_ack === 1'b1 && i_ack === 1'b1) ok = 1'b0;
            if (d_ack === 1'b1) begin
                seq[cnt] = 1'b1; t[cnt] = n; cnt++;
                if (d_dout !== ref_mem[8'h00]) data_ok = 1'b0;
            end else if (i_ack === 1'b1) begin
                seq[cnt] = 1'b0; t[cnt] = n; cnt++;
                if (i_dout !== ref_mem[8'h21]) data_ok = 1'b0;
            end
        end
        d_acc = 1'b0; i_acc = 1'b0;
        tick; tick;
        checks++;
        if (cnt !== 8) begin errors++; $display("FAIL b2b_count got %0d expected 8", cnt); end
        for (int k = 1; k < cnt; k++) if (seq[k] == seq[k-1] || t[k] - t[k-1] != 4) ok = 1'b0;
        checks++;
        if (cnt < 1 || seq[0] !== 1'b1) begin errors++; $display("FAIL b2b_first got instr expected data"); end
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_alternation got non-alternating or gap!=4 expected strict alternation"); end
        checks++;
        if (!data_ok) begin errors++; $display("FAIL b2b_data got wrong read word expected stored words"); end
    endtask

    task automatic test_ws0;
        int lat, ce_n;
        bit ok;
        logic [15:0] dv;
        lat = -1; ce_n = 0; ok = 1'b1; dv = '0;
        z_i_addr = 19'($urandom); z_i_acc = 1'b1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            tick;
            if (z_s_ce) begin
                ce_n++;
                if (z_s_be !== 2'b11 || z_s_we !== 1'b0 || z_s_addr !== z_i_addr) ok = 1'b0;
            end
            if (z_i_ack === 1'b1) begin lat = n; dv = z_i_dout; z_i_acc = 1'b0; end
        end
        z_i_acc = 1'b0;
        tick;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL ws0_latency got %0d expected 2", lat); end
        checks++;
        if (ce_n !== 1 || !ok) begin errors++; $display("FAIL ws0_strobes got ce=%0d ok=%0d expected ce=1 ok=1", ce_n, ok); end
        checks++;
        if (dv !== ref_mem[z_i_addr[7:0]]) begin errors++; $display("FAIL ws0_data got %h expected %h", dv, ref_mem[z_i_addr[7:0]]); end
    endtask

    task automatic test_reset_abort;
        bit stray;
        stray = 1'b0;
        d_addr = 19'h00055; d_wr = 1'b0; d_be = 2'b11; d_acc = 1'b1;
        tick;
        checks++;
        if (s_ce !== 1'b1) begin errors++; $display("FAIL abort_in_access got ce=%b expected 1", s_ce); end
        reset = 1'b0; d_acc = 1'b0;
        tick;
        checks++;
        if ({s_ce, s_we, s_be} !== 4'b0 || {d_ack, i_ack} !== 2'b00) begin
            errors++; $display("FAIL abort_strobes got %b acks %b expected 0000 00", {s_ce, s_we, s_be}, {d_ack, i_ack});
        end
        tick;
        reset = 1'b1;
        repeat (4) begin
            tick;
            if (d_ack !== 1'b0 || i_ack !== 1'b0 || s_ce !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL abort_no_ack got stray ack/ce expected none"); end
        run_txn(1'b1, 1'b0, 19'h00055, 16'h0, 2'b11);
        checks++;
        if (r_lat !== 3 || r_dout !== ref_mem[8'h55]) begin
            errors++; $display("FAIL abort_fresh got lat=%0d %h expected lat=3 %h", r_lat, r_dout, ref_mem[8'h55]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset = 1'b0;
        i_addr = '0; i_acc = 1'b0; d_addr = '0; d_din = '0; d_acc = 1'b0; d_wr = 1'b0; d_be = '0;
        z_i_addr = '0; z_i_acc = 1'b0;
        tick; tick;
        test_reset;
        test_read;
        test_write;
        test_random;
        test_contention;
        test_back_to_back;
        test_ws0;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1, range 0..15: extra SRAM cycles per access beyond the first.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 instr_m_addr  in  19  instruction fetch word address [19:1].
REQ-005 instr_m_access  in  1  instruction read request, held until ack.
REQ-006 instr_m_ack  out  1  one-cycle completion pulse, instruction port.
REQ-007 instr_m_data_out  out  16  read data to instruction master.
REQ-008 data_m_addr  in  19  data word address [19:1].
REQ-009 data_m_data_in  in  16  write data from data master.
REQ-010 data_m_data_out  out  16  read data to data master.
REQ-011 data_m_access  in  1  data request, held until ack.
REQ-012 data_m_ack  out  1  one-cycle completion pulse, data port.
REQ-013 data_m_wr_en  in  1  1 = write, 0 = read.
REQ-014 data_m_bytesel  in  2  byte enables, [0] low byte, [1] high byte.
REQ-015 sram_addr  out  19  SRAM word address.
REQ-016 sram_wdata  out  16  SRAM write data.
REQ-017 sram_rdata  in  16  SRAM read data, valid the cycle after sram_ce asserted and stable while held.
REQ-018 sram_ce / sram_we  out  1 each  SRAM chip enable / write enable.
REQ-019 sram_be  out  2  SRAM byte enables.

Function
REQ-020 FSM states IDLE, ACCESS, ACK; transitions only on rising clk.
REQ-021 IDLE: on any access high, latch granted port, address, wr_en, bytesel, wdata; go to ACCESS; else stay.
REQ-022 Contention (both access high in IDLE): grant port not granted last; last_grant updated on every grant.
REQ-023 ACCESS lasts exactly WAIT_STATES+1 cycles, counted by 4-bit down-counter; sram_ce=1 throughout, sram_addr/sram_be/sram_wdata from latched values.
REQ-024 sram_we=1 throughout ACCESS only when the latched request is a data write; instruction port never writes.
REQ-025 sram_be = latched bytesel for data port, 2'b11 for instruction port.
REQ-026 Final ACCESS cycle: capture sram_rdata into read register; go to ACK.
REQ-027 ACK: exactly one cycle; granted port's ack=1; its data_out = captured word (writes: 16'h0000); go to IDLE.
REQ-028 Latency: access first high in IDLE cycle T -> ack in cycle T+2+WAIT_STATES when uncontended.
REQ-029 Access seen in the ACK cycle is ignored; next request sampled in IDLE at T+3+WAIT_STATES.
REQ-030 Both data_out buses 16'h0000 and both acks 0 outside their own ACK cycle.
REQ-031 Request inputs changing after grant have no effect on the in-flight access.
REQ-032 No access is ever dropped: a port held high is granted within one other transaction.

Reset
REQ-033 reset low at rising clk: state IDLE, counter 0, last_grant = instruction (data wins first tie).
REQ-034 Outputs during/after reset: acks 0, data_out 0, sram_ce/we 0, sram_be 2'b00, sram_addr/wdata 0.
REQ-035 Reset mid-ACCESS or mid-ACK aborts the transaction; no ack is issued for it.

Structure
REQ-036 Shared package holds FSM state enum, port-id enum (PORT_INSTR, PORT_DATA), WAIT_STATES width constant.
REQ-037 One sub-module mem_arbiter: combinational two-way round-robin grant from the two access bits and last_grant.

Verification
REQ-038 WAIT_STATES=1; data read 0x12345, SRAM word 0xBEEF -> data_m_ack at T+3, data_m_data_out=0xBEEF that cycle only.
REQ-039 Data write addr 0x00010, wdata 0xA55A, bytesel 2'b10 -> sram_we=1, sram_be=2'b10 for 2 cycles, ack at T+3.
REQ-040 Both ports request simultaneously after reset -> data served first, instruction ack exactly 4 cycles after data ack.
REQ-041 Both ports held high continuously for 8 transactions -> grants strictly alternate, no starvation.
REQ-042 WAIT_STATES=0 instruction fetch -> ack at T+2, sram_be=2'b11, sram_we=0.
REQ-043 reset asserted during ACCESS -> no ack, all SRAM strobes 0 next cycle, fresh request after release completes normally.
